// File: rtl/aq_spsram_init_ctrl_if.sv
// Access bus for aq_spsram_init_ctrl: active-low SRAM-style pins plus the
// clear-sequencer handshake. par_err exists only when AQ_SPSRAM_PARITY_EN is
// defined.
interface aq_spsram_init_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 98,
  parameter int WE_WIDTH   = 98
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [WE_WIDTH-1:0]   WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  init_req;
  logic                  init_busy;
  logic                  init_done;
`ifdef AQ_SPSRAM_PARITY_EN
  logic                  par_err;

  modport master (output A, CEN, GWEN, WEN, D, init_req,
                  input  Q, init_busy, init_done, par_err);
  modport slave  (input  A, CEN, GWEN, WEN, D, init_req,
                  output Q, init_busy, init_done, par_err);
`else
  modport master (output A, CEN, GWEN, WEN, D, init_req,
                  input  Q, init_busy, init_done);
  modport slave  (input  A, CEN, GWEN, WEN, D, init_req,
                  output Q, init_busy, init_done);
`endif
endinterface

// File: rtl/aq_spsram_init_ctrl.sv
// Parametrised single-port SRAM with a hardware clear sequencer, held read
// data register and grouped active-low write masks.
// Optional: define AQ_SPSRAM_PARITY_EN to store one even-parity bit per write
// group and report read parity errors on par_err.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clearing: writes INIT_VAL to entry cnt each cycle, busy
// ST_IDLE | normal access; init_req restarts the clear from entry 0
module aq_spsram_init_ctrl #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 98,
  parameter int                    WE_WIDTH   = 98,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input logic                  forever_cpuclk,
  input logic                  cpurst_b,
  aq_spsram_init_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int GW    = DATA_WIDTH / WE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_we;
  logic                  busy;
  logic                  done;
  logic                  acc_rd;
  logic                  acc_wr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] q_r;

  // State and clear-counter registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, clear-write strobe and status outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt_q == LAST) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        // init_req wins only from the next cycle; this cycle's access still goes
        if (bus.init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign acc_rd = (state_q == ST_IDLE) && !bus.CEN &&  bus.GWEN;
  assign acc_wr = (state_q == ST_IDLE) && !bus.CEN && !bus.GWEN;

  assign bus.init_busy = busy;
  assign bus.init_done = done;
  assign bus.Q         = q_r;

  // Array write port: clear sequence or masked group write (mutually exclusive by state)
  always_ff @(posedge forever_cpuclk) begin
    if (clr_we) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (acc_wr) begin
      for (int g = 0; g < WE_WIDTH; g++) begin
        if (!bus.WEN[g]) mem[bus.A][g*GW +: GW] <= bus.D[g*GW +: GW];
      end
    end
  end

  // Read data register, held until the next read (also across a clear)
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      q_r <= '0;
    end else if (acc_rd) begin
      q_r <= mem[bus.A];
    end
  end

`ifdef AQ_SPSRAM_PARITY_EN
  logic [WE_WIDTH-1:0] par_mem [DEPTH];
  logic                par_err_r;

  function automatic logic [WE_WIDTH-1:0] par_of(input logic [DATA_WIDTH-1:0] d);
    logic [WE_WIDTH-1:0] p;
    p = '0;
    for (int g = 0; g < WE_WIDTH; g++) p[g] = ^d[g*GW +: GW];
    return p;
  endfunction

  // Parity array follows the data array write for write for every group
  always_ff @(posedge forever_cpuclk) begin
    if (clr_we) begin
      par_mem[cnt_q] <= par_of(INIT_VAL);
    end else if (acc_wr) begin
      for (int g = 0; g < WE_WIDTH; g++) begin
        if (!bus.WEN[g]) par_mem[bus.A][g] <= ^bus.D[g*GW +: GW];
      end
    end
  end

  // Parity check registered alongside Q; zero on every non-read cycle
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      par_err_r <= 1'b0;
    end else begin
      par_err_r <= acc_rd && (|(par_of(mem[bus.A]) ^ par_mem[bus.A]));
    end
  end

  assign bus.par_err = par_err_r;
`endif
endmodule

// File: tb/tb_aq_spsram_init_ctrl.sv
// Self-checking bench for aq_spsram_init_ctrl. Read expectations come from a
// bench-side array model and are queued when the read is issued, then popped
// when Q is sampled after the edge.
module tb_aq_spsram_init_ctrl;
  localparam int AW    = 6;
  localparam int DW    = 98;
  localparam int WW    = 98;
  localparam int GW    = DW / WW;
  localparam int DEPTH = 1 << AW;

  logic clk    = 1'b0;
  logic rst_b  = 1'b0;

  aq_spsram_init_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) bus ();

  aq_spsram_init_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .INIT_VAL('0)
  ) dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_b),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ones;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.A        = '0;
    bus.CEN      = 1'b1;
    bus.GWEN     = 1'b1;
    bus.WEN      = '1;
    bus.D        = '0;
    bus.init_req = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [WW-1:0] wen);
    bus.A    = addr;
    bus.CEN  = 1'b0;
    bus.GWEN = 1'b0;
    bus.WEN  = wen;
    bus.D    = data;
    if (!bus.init_busy) begin
      for (int g = 0; g < WW; g++)
        if (!wen[g]) model[addr][g*GW +: GW] = data[g*GW +: GW];
    end
    tick();
    idle_inputs();
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input string name);
    logic [DW-1:0] e;
    bus.A    = addr;
    bus.CEN  = 1'b0;
    bus.GWEN = 1'b1;
    bus.WEN  = '0;
    exp_q.push_back(model[addr]);
    tick();
    idle_inputs();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (bus.Q !== e) begin
        errors++;
        $display("FAIL %s addr=%0d got=%h expected=%h", name, addr, bus.Q, e);
      end
    end
  endtask

  // Runs until init_busy drops; optionally pulses init_req or attempts a write to A=3 at given busy cycles.
  task automatic wait_clear(input int req_at, input int wr_at,
                            output int busy_cycles, output int done_cycle, output int done_cnt);
    int n;
    n = 0;
    done_cycle = 0;
    done_cnt = 0;
    while (bus.init_busy && n < 200) begin
      n++;
      if (n == req_at) bus.init_req = 1'b1;
      if (n == wr_at) begin
        bus.A = AW'(3); bus.CEN = 1'b0; bus.GWEN = 1'b0; bus.WEN = '0; bus.D = ones;
      end
      if (bus.init_done) begin
        done_cnt++;
        done_cycle = n;
      end
      tick();
      idle_inputs();
    end
    busy_cycles = n;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    int bc, dc, dn;
    idle_inputs();
    rst_b = 1'b0;
    #12;
    checks++;
    if (bus.Q !== '0) begin errors++; $display("FAIL rst_q got=%h expected=0", bus.Q); end
    checks++;
    if (bus.init_busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b expected=1", bus.init_busy); end
    checks++;
    if (bus.init_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b expected=0", bus.init_done); end
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    wait_clear(0, 0, bc, dc, dn);
    checks++;
    if (bc != 64) begin errors++; $display("FAIL boot_busy_cycles got=%0d expected=64", bc); end
    checks++;
    if (dc != 64) begin errors++; $display("FAIL boot_done_cycle got=%0d expected=64", dc); end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL boot_done_pulses got=%0d expected=1", dn); end
    checks++;
    if (bus.init_busy !== 1'b0) begin errors++; $display("FAIL boot_busy_after got=%b expected=0", bus.init_busy); end
    do_read(AW'(0),  "boot_read0");
    do_read(AW'(31), "boot_read31");
    do_read(AW'(63), "boot_read63");
  endtask

  task automatic test_full_write();
    do_write(AW'(5), ones, '0);
    checks++;
    if (bus.Q !== '0) begin errors++; $display("FAIL write_no_through got=%h expected=0", bus.Q); end
    do_read(AW'(5), "full_read5");
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.Q !== ones) begin errors++; $display("FAIL q_hold got=%h expected=%h", bus.Q, ones); end
    end
  endtask

  task automatic test_partial_write();
    logic [WW-1:0] wen;
    wen = '1;
    wen[48:0] = '0;
    do_write(AW'(7), ones, wen);
    do_read(AW'(7), "partial_read7");
    checks++;
    if (bus.Q[48:0] !== {49{1'b1}} || bus.Q[97:49] !== {49{1'b0}}) begin
      errors++;
      $display("FAIL partial_split got=%h expected lower 49 ones upper 49 zeros", bus.Q);
    end
  endtask

  task automatic test_init_req();
    int bc, dc, dn;
    do_write(AW'(3), ones, '0);
    do_read(AW'(3), "pre_req_read3");
    // init_req together with a read of A=5: the read still completes
    bus.init_req = 1'b1;
    bus.A = AW'(5); bus.CEN = 1'b0; bus.GWEN = 1'b1;
    exp_q.push_back(model[5]);
    tick();
    idle_inputs();
    checks++;
    if (bus.Q !== exp_q.pop_front()) begin errors++; $display("FAIL req_cycle_read got=%h expected=%h", bus.Q, ones); end
    checks++;
    if (bus.init_busy !== 1'b1) begin errors++; $display("FAIL req_busy got=%b expected=1", bus.init_busy); end
    wait_clear(20, 10, bc, dc, dn);
    checks++;
    if (bc != 64) begin errors++; $display("FAIL req_busy_cycles got=%0d expected=64", bc); end
    checks++;
    if (dn != 1 || dc != 64) begin errors++; $display("FAIL req_done got=%0d@%0d expected=1@64", dn, dc); end
    checks++;
    if (bus.Q !== ones) begin errors++; $display("FAIL q_hold_clear got=%h expected=%h", bus.Q, ones); end
    do_read(AW'(3), "busy_write_dropped");
    do_read(AW'(5), "cleared_read5");
  endtask

  task automatic test_reset_midclear();
    int bc, dc, dn;
    do_write(AW'(5), ones, '0);
    do_read(AW'(5), "pre_rst_read5");
    bus.init_req = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 19; i++) tick();
    rst_b = 1'b0;
    #2;
    checks++;
    if (bus.Q !== '0) begin errors++; $display("FAIL midrst_q got=%h expected=0", bus.Q); end
    checks++;
    if (bus.init_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got=%b expected=1", bus.init_busy); end
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    wait_clear(0, 0, bc, dc, dn);
    checks++;
    if (bc != 64) begin errors++; $display("FAIL midrst_busy_cycles got=%0d expected=64", bc); end
    checks++;
    if (bus.Q !== '0) begin errors++; $display("FAIL midrst_q_after got=%h expected=0", bus.Q); end
    do_read(AW'(5), "midrst_read5");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [8];
    for (int i = 0; i < 8; i++) begin
      addrs[i] = AW'($urandom_range(0, DEPTH - 1));
      do_write(addrs[i], DW'({$urandom, $urandom, $urandom, $urandom}),
               (i % 2 == 0) ? '0 : WW'({$urandom, $urandom, $urandom, $urandom}));
    end
    for (int i = 7; i >= 0; i--) do_read(addrs[i], "b2b_read");
    do_read(AW'(7), "b2b_read7");
  endtask

`ifdef AQ_SPSRAM_PARITY_EN
  task automatic test_parity();
    dut.mem[9][0] = ~dut.mem[9][0];
    bus.A = AW'(9); bus.CEN = 1'b0; bus.GWEN = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (bus.par_err !== 1'b1) begin errors++; $display("FAIL par_err_set got=%b expected=1", bus.par_err); end
    tick();
    checks++;
    if (bus.par_err !== 1'b0) begin errors++; $display("FAIL par_err_one_cycle got=%b expected=0", bus.par_err); end
    bus.A = AW'(5); bus.CEN = 1'b0; bus.GWEN = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (bus.par_err !== 1'b0) begin errors++; $display("FAIL par_err_clean got=%b expected=0", bus.par_err); end
  endtask
`endif

  initial begin
    ones = '1;
    test_reset();
    test_full_write();
    test_partial_write();
    test_init_req();
    test_reset_midclear();
    test_back_to_back();
`ifdef AQ_SPSRAM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
